inv_roundkey_gen: RTL and testbench

Iterative inverse AES-128 key-schedule engine for the decryption datapath. It accepts the final (round-10) key and streams round keys 10, 9, … 0 to the inverse-cipher rounds under a valid/ready handshake. It computes one round key per accepted transfer. It is the reverse-direction counterpart of the forward round-key generator, and holds the round-constant sequence internally.

---
 rtl/inv_roundkey_gen.sv | 121 ++++++++++++
 tb/tb_inv_roundkey_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_roundkey_gen.sv
// Inverse AES-128 key-schedule engine: walks from the round-10 key back to the
// cipher key, presenting one round key per accepted valid/ready transfer.
module inv_roundkey_gen (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         ready_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         valid_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SboxTable[idx -: 8];
  endfunction

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, p3, rot_word, sub_word;
  logic [7:0]   rcon;
  logic [127:0] prev_key;

  assign {w0, w1, w2, w3} = key_q;
  assign p3               = w3 ^ w2;
  assign rot_word         = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_word[8*i +: 8] = sbox(rot_word[8*i +: 8]);
  end

  // Round constant belongs to the round being undone (the current round_num).
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd10:   rcon = 8'h36;
      4'd9:    rcon = 8'h1b;
      4'd8:    rcon = 8'h80;
      4'd7:    rcon = 8'h40;
      4'd6:    rcon = 8'h20;
      4'd5:    rcon = 8'h10;
      4'd4:    rcon = 8'h08;
      4'd3:    rcon = 8'h04;
      4'd2:    rcon = 8'h02;
      4'd1:    rcon = 8'h01;
      default: rcon = 8'h00;
    endcase
  end

  assign prev_key = {w0 ^ sub_word ^ {rcon, 24'h000000}, w1 ^ w0, w2 ^ w1, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = last_key;
          round_d = 4'd10;
          state_d = StRun;
        end
      end
      StRun: begin
        if (ready_in) begin
          if (round_q != 4'd0) begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_num = round_q;
  assign valid_out = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = done_q;

endmodule

// File: tb/tb_inv_roundkey_gen.sv
// Directed bench for inv_roundkey_gen: scoreboard of round keys from a software
// inverse key schedule with an S-box derived from GF(2^8) arithmetic.
module tb_inv_roundkey_gen;

  logic         clk = 1'b0;
  logic         reset, start, ready_in;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         valid_out, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;
  exp_t sb[$];

  localparam logic [127:0] FipsK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FipsK9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FipsK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_roundkey_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .last_key  (last_key),
    .ready_in  (ready_in),
    .round_key (round_key),
    .round_num (round_num),
    .valid_out (valid_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_m(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction

  function automatic logic [127:0] inv_step_m(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, p3, t;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    t  = {p3[23:0], p3[31:24]};
    for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox_m(t[8*i +: 8]);
    return {w0 ^ t ^ {rcon_m(r), 24'h000000}, w1 ^ w0, w2 ^ w1, p3};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [127:0] k10);
    logic [127:0] k;
    exp_t e;
    k = k10;
    for (int r = 10; r >= 0; r--) begin
      e.r = 4'(r);
      e.k = k;
      sb.push_back(e);
      if (r > 0) k = inv_step_m(k, r);
    end
  endtask

  // Called at a negedge; returns at the negedge where round 10 should be visible.
  task automatic do_start(input logic [127:0] k);
    start    = 1'b1;
    last_key = k;
    ready_in = 1'b1;
    push_stream(k);
    @(negedge clk);
    start    = 1'b0;
    last_key = rnd128();
  endtask

  task automatic drain(input bit rand_ready, input bit poke, input bit fips, input bit chain,
                       input logic [127:0] chain_key, input string name);
    int           cyc;
    bit           held, fin;
    logic [127:0] pk;
    logic [3:0]   pn;
    exp_t         e;
    held = 1'b0;
    fin  = 1'b0;
    chk({name, " first valid"}, 128'(valid_out), 128'(1'b1));
    for (cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (held) begin
        chk({name, " hold key"}, round_key, pk);
        chk({name, " hold num"}, 128'(round_num), 128'(pn));
      end
      chk({name, " done low in run"}, 128'(done), 128'(1'b0));
      ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = poke && (round_num == 4'd6);
      if (start) last_key = rnd128();
      held = !ready_in;
      pk   = round_key;
      pn   = round_num;
      if (ready_in) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s scoreboard observed=extra_key expected=none", name);
        end else begin
          e = sb.pop_front();
          chk({name, " round num"}, 128'(round_num), 128'(e.r));
          chk({name, " round key"}, round_key, e.k);
        end
        if (fips) begin
          case (round_num)
            4'd9:    chk({name, " fips r9"}, round_key, FipsK9);
            4'd1:    chk({name, " fips r1"}, round_key, FipsK1);
            4'd0:    chk({name, " fips r0"}, round_key, FipsK0);
            default: ;
          endcase
        end
        if (round_num == 4'd0) fin = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s timeout observed=no_round0 expected=round0_transfer", name);
    end
    if (!rand_ready) chk({name, " done latency"}, 128'(cyc), 128'(11));
    chk({name, " done pulse"}, 128'(done), 128'(1'b1));
    chk({name, " busy at done"}, 128'(busy), 128'(1'b0));
    chk({name, " valid at done"}, 128'(valid_out), 128'(1'b0));
    chk({name, " sb empty"}, 128'(sb.size()), 128'(0));
    if (chain) begin
      do_start(chain_key);
    end else begin
      @(negedge clk);
      chk({name, " done one cycle"}, 128'(done), 128'(1'b0));
      chk({name, " idle valid"}, 128'(valid_out), 128'(1'b0));
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " key"}, round_key, 128'h0);
    chk({name, " num"}, 128'(round_num), 128'h0);
    chk({name, " valid"}, 128'(valid_out), 128'h0);
    chk({name, " busy"}, 128'(busy), 128'h0);
    chk({name, " done"}, 128'(done), 128'h0);
  endtask

  initial begin
    int   n;
    exp_t e;
    reset    = 1'b0;
    start    = 1'b0;
    ready_in = 1'b0;
    last_key = '0;

    // Reset held with random inputs toggling.
    repeat (4) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      last_key = rnd128();
      chk_zero("reset");
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post reset valid", 128'(valid_out), 128'h0);
      chk("post reset busy", 128'(busy), 128'h0);
    end

    do_start(FipsK10);
    drain(1'b0, 1'b0, 1'b1, 1'b0, '0, "fips");

    do_start(FipsK10);
    drain(1'b1, 1'b0, 1'b1, 1'b0, '0, "backpressure");

    do_start(FipsK10);
    drain(1'b0, 1'b1, 1'b1, 1'b0, '0, "ignored start");

    // Mid-schedule reset at round 5.
    do_start(FipsK10);
    n = 0;
    while (round_num != 4'd5 && n < 20) begin
      ready_in = 1'b1;
      e = sb.pop_front();
      chk("midrst round num", 128'(round_num), 128'(e.r));
      chk("midrst round key", round_key, e.k);
      @(negedge clk);
      n++;
    end
    chk("midrst reached r5", 128'(round_num), 128'(4'd5));
    #2 reset = 1'b0;
    #1 chk_zero("async reset");
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      chk_zero("reset held");
    end
    reset = 1'b1;
    @(negedge clk);
    chk("after midrst done", 128'(done), 128'h0);
    chk("after midrst valid", 128'(valid_out), 128'h0);

    do_start(FipsK10);
    drain(1'b0, 1'b0, 1'b1, 1'b1, 128'h0, "restart");
    drain(1'b0, 1'b0, 1'b0, 1'b0, '0, "zero key");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
